ex_mem_pipe_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register with valid/ready handshake and a one-entry

---
 rtl/ex_mem_pkg.sv | 26 ++
 rtl/pipe_entry_reg.sv | 33 +++
 rtl/ex_mem_pipe_reg.sv | 125 ++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control-bit indices,
// default payload widths, the "no MOV" opcode and the packed entry layout.
package ex_mem_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 2;
    localparam int CTRL_W  = 4;
    localparam int MOVOP_W = 4;
    localparam int REG_AW  = 4;

    // Bit positions inside the MEM/WB control field
    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_R15      = 3;

    localparam logic [MOVOP_W-1:0] MOV_NONE = 4'h0;

    typedef struct packed {
        logic [NUM_CH*DATA_W-1:0] result;
        logic [CTRL_W-1:0]        ctrl;
        logic [MOVOP_W-1:0]       movop;
        logic [REG_AW-1:0]        dest;
    } ex_mem_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of the pipeline register: a valid flag plus a payload of
// any packed type. 'clear' wins over 'load'; clearing leaves the payload
// stale, consumers gate anything dangerous with the valid flag.
module pipe_entry_reg
    import ex_mem_pkg::*;
#(
    parameter type entry_t = ex_mem_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   clear,
    input  entry_t d,
    output logic   valid,
    output entry_t q
);

    // Slot state: reset empties it, clear drops it, load captures a new entry
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload is reset too (not only valid) because every output of
        // the block must read zero while rst_n is low; state always uses <=.
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake and a one-entry skid
// slot. M (main) drives the MEM-side outputs, S (skid) catches the entry that
// arrives while MEM stalls, so in_ready can be a pure register output.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = ex_mem_pkg::DATA_W,
    parameter int NUM_CH  = ex_mem_pkg::NUM_CH,
    parameter int CTRL_W  = ex_mem_pkg::CTRL_W,
    parameter int MOVOP_W = ex_mem_pkg::MOVOP_W,
    parameter int REG_AW  = ex_mem_pkg::REG_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_result,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [MOVOP_W-1:0]       in_movop,
    input  logic [REG_AW-1:0]        in_dest,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_result,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [MOVOP_W-1:0]       out_movop,
    output logic [REG_AW-1:0]        out_dest,
    output logic                     fwd_valid,
    output logic [REG_AW-1:0]        fwd_dest,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [1:0]               occupancy
);

    // Entry layout built from this instance's parameters (matches ex_mem_entry_t at defaults)
    typedef struct packed {
        logic [NUM_CH*DATA_W-1:0] result;
        logic [CTRL_W-1:0]        ctrl;
        logic [MOVOP_W-1:0]       movop;
        logic [REG_AW-1:0]        dest;
    } entry_t;

    entry_t in_entry, m_d, m_q, s_q;
    logic   m_valid, s_valid;
    logic   m_load, m_clear, m_from_skid, s_load, s_clear;
    logic   accept, emit, s_valid_next;

    assign in_entry = '{result: in_result, ctrl: in_ctrl, movop: in_movop, dest: in_dest};
    assign accept   = in_valid & in_ready;
    assign emit     = m_valid & out_ready;
    assign m_d      = m_from_skid ? s_q : in_entry;

    // Slot steering: flush beats everything; S is only ever filled behind a full M
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (emit) begin
            if (s_valid) begin
                m_load      = 1'b1;
                m_from_skid = 1'b1;
                s_load      = accept;
                s_clear     = !accept;
            end else if (accept) begin
                m_load = 1'b1;
            end else begin
                m_clear = 1'b1;
            end
        end else if (accept) begin
            m_load = !m_valid;
            s_load = m_valid;
        end
    end

    pipe_entry_reg #(.entry_t(entry_t)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .valid (m_valid),
        .q     (m_q)
    );

    pipe_entry_reg #(.entry_t(entry_t)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_entry),
        .valid (s_valid),
        .q     (s_q)
    );

    assign s_valid_next = s_load | (s_valid & ~s_clear);

    // in_ready mirrors the next skid state so it is a flop output with no path
    // from out_ready; it reads 0 during reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= ~s_valid_next;
        end
    end

    assign out_valid  = m_valid;
    assign out_result = m_q.result;
    assign out_ctrl   = m_valid ? m_q.ctrl : '0;
    assign out_movop  = m_q.movop;
    assign out_dest   = m_q.dest;
    assign occupancy  = {1'b0, m_valid} + {1'b0, s_valid};

    // Loads (MEMTOREG) have no data yet at this stage, so they never forward
    assign fwd_valid = out_valid & ~out_ctrl[CTRL_MEMTOREG]
                     & (out_ctrl[CTRL_R15] | (out_movop != MOVOP_W'(MOV_NONE)));
    assign fwd_dest  = out_dest;
    assign fwd_data  = out_result[DATA_W-1:0];

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg. The reference model is a bounded
// FIFO (capacity 2) of entries plus a registered ready flag.
module tb_ex_mem_pipe_reg;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic [3:0]  mov;
        logic [3:0]  dest;
    } tb_ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic [3:0]  in_ctrl = '0;
    logic [3:0]  in_movop = '0;
    logic [3:0]  in_dest = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_ctrl;
    logic [3:0]  out_movop;
    logic [3:0]  out_dest;
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [15:0] fwd_data;
    logic [1:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    tb_ent_t q[$];
    bit      m_rdy = 1'b0;

    ex_mem_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_ctrl(in_ctrl), .in_movop(in_movop), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ctrl(out_ctrl), .out_movop(out_movop), .out_dest(out_dest),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic tb_ent_t rand_ent();
        tb_ent_t e;
        e.res  = $urandom;
        e.ctrl = 4'($urandom);
        e.mov  = 4'($urandom);
        e.dest = 4'($urandom);
        return e;
    endfunction

    function automatic tb_ent_t mk(input logic [15:0] ch0, input logic [3:0] ctrl,
                                   input logic [3:0] mov, input logic [3:0] dest);
        tb_ent_t e;
        e.res  = {16'($urandom), ch0};
        e.ctrl = ctrl;
        e.mov  = mov;
        e.dest = dest;
        return e;
    endfunction

    // Forwarding rule: valid, not a load, and writes a register (R15 or a MOV)
    function automatic bit model_fwd();
        if (q.size() == 0) return 1'b0;
        return !q[0].ctrl[0] && (q[0].ctrl[3] || q[0].mov != 4'h0);
    endfunction

    task automatic present(input bit v, input tb_ent_t e);
        in_valid  = v;
        in_result = e.res;
        in_ctrl   = e.ctrl;
        in_movop  = e.mov;
        in_dest   = e.dest;
    endtask

    // Advance one clock and step the FIFO model with the inputs seen at the edge
    task automatic cycle();
        tb_ent_t cur;
        bit acc, emi;
        @(posedge clk);
        cur.res = in_result; cur.ctrl = in_ctrl; cur.mov = in_movop; cur.dest = in_dest;
        acc = in_valid && m_rdy;
        emi = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (emi) void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        m_rdy = (q.size() < 2);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        n_tests++; if (out_ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            present(1'b1, mk(16'(i), 4'($urandom), 4'($urandom), 4'($urandom)));
            cycle();
            n_tests++; if (out_valid !== 1'b1 || out_result[15:0] !== 16'(i)) begin
                n_fail++; $display("FAIL stream_ch0[%0d] valid=%b got=%h exp=%h", i, out_valid, out_result[15:0], 16'(i));
            end
            n_tests++; if (in_ready !== 1'b1 || occupancy > 2'd1) begin
                n_fail++; $display("FAIL stream_ready_occ[%0d] in_ready=%b occ=%0d exp ready=1 occ<=1", i, in_ready, occupancy);
            end
        end
        present(1'b0, rand_ent());
        cycle();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        tb_ent_t a, b, c;
        logic [15:0] got[$];
        int cyc;
        a = rand_ent(); b = rand_ent(); c = rand_ent();
        out_ready = 1'b0;
        present(1'b1, a); cycle();
        present(1'b1, b); cycle();
        present(1'b1, c); cycle();
        n_tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_full occ=%0d in_ready=%b exp occ=2 ready=0", occupancy, in_ready);
        end
        n_tests++; if (out_result !== a.res) begin
            n_fail++; $display("FAIL stall_head got=%h exp=%h", out_result, a.res);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 3 && cyc < 10) begin
            if (out_valid) got.push_back(out_result[15:0]);
            if (in_valid && in_ready) begin
                cycle();
                present(1'b0, rand_ent());
            end else begin
                cycle();
            end
            cyc++;
        end
        present(1'b0, rand_ent());
        n_tests++; if (got.size() != 3 || got[0] !== a.res[15:0] || got[1] !== b.res[15:0] || got[2] !== c.res[15:0]) begin
            n_fail++; $display("FAIL stall_order got_n=%0d exp A=%h B=%h C=%h", got.size(), a.res[15:0], b.res[15:0], c.res[15:0]);
        end
        n_tests++; if (cyc > 4) begin n_fail++; $display("FAIL stall_gaps cycles=%0d exp<=4", cyc); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        present(1'b1, rand_ent()); cycle();
        present(1'b1, rand_ent()); cycle();
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_fill occ=%0d exp=2", occupancy); end
        out_ready = 1'($urandom);
        present(1'b1, mk(16'hD00D, 4'b1110, 4'h3, 4'h7));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        present(1'b0, rand_ent());
        n_tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 4'h0) begin
            n_fail++; $display("FAIL flush_clear valid=%b occ=%0d ctrl=%h exp 0/0/0", out_valid, occupancy, out_ctrl);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_memwrite_flush();
        out_ready = 1'b1;
        present(1'b1, mk(16'h1234, 4'b0010, 4'h0, 4'h2));
        cycle();
        present(1'b0, rand_ent());
        n_tests++; if (out_ctrl !== 4'b0010) begin n_fail++; $display("FAIL memwrite_pass got=%b exp=0010", out_ctrl); end
        cycle();
        present(1'b1, mk(16'h5678, 4'b0010, 4'h0, 4'h2));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        present(1'b0, rand_ent());
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (out_ctrl[1] !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL memwrite_flush[%0d] memwrite=%b valid=%b exp 0/0", i, out_ctrl[1], out_valid);
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        present(1'b1, mk(16'hAAAA, 4'hF, 4'hF, 4'hF)); cycle();
        present(1'b1, mk(16'h5555, 4'hE, 4'hE, 4'hE)); cycle();
        present(1'b0, rand_ent());
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL rstmid_fill occ=%0d exp=2", occupancy); end
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_rdy = 1'b0;
        n_tests++; if ({out_valid, out_result, out_ctrl, out_movop, out_dest, occupancy, in_ready} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs valid=%b res=%h ctrl=%h mov=%h dest=%h occ=%0d rdy=%b exp all 0",
                               out_valid, out_result, out_ctrl, out_movop, out_dest, occupancy, in_ready);
        end
        n_tests++; if ({fwd_valid, fwd_dest, fwd_data} !== '0) begin
            n_fail++; $display("FAIL rstmid_fwd valid=%b dest=%h data=%h exp 0", fwd_valid, fwd_dest, fwd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_release in_ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_forward();
        tb_ent_t cases[4];
        bit      exp_fwd[4];
        cases[0] = mk(16'hBEEF, 4'b1000, 4'h0, 4'hF); exp_fwd[0] = 1'b1;
        cases[1] = mk(16'hBEEF, 4'b1001, 4'h0, 4'hF); exp_fwd[1] = 1'b0;
        cases[2] = mk(16'hC0DE, 4'b0000, 4'h3, 4'h5); exp_fwd[2] = 1'b1;
        cases[3] = mk(16'hC0DE, 4'b0000, 4'h0, 4'h5); exp_fwd[3] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(1'b1, cases[i]);
            cycle();
            present(1'b0, rand_ent());
            n_tests++; if (fwd_valid !== exp_fwd[i]) begin
                n_fail++; $display("FAIL fwd_valid[%0d] got=%b exp=%b", i, fwd_valid, exp_fwd[i]);
            end
            n_tests++; if (fwd_dest !== cases[i].dest || fwd_data !== cases[i].res[15:0]) begin
                n_fail++; $display("FAIL fwd_payload[%0d] dest=%h data=%h exp %h/%h", i, fwd_dest, fwd_data, cases[i].dest, cases[i].res[15:0]);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            present(1'($urandom_range(0, 3) != 0), rand_ent());
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
            n_tests++; if (out_valid !== (q.size() > 0) || occupancy !== 2'(q.size()) || in_ready !== m_rdy) begin
                n_fail++; $display("FAIL rand_state[%0d] valid=%b occ=%0d rdy=%b exp %b/%0d/%b",
                                   i, out_valid, occupancy, in_ready, q.size() > 0, q.size(), m_rdy);
            end
            if (q.size() > 0) begin
                n_tests++; if (out_result !== q[0].res || out_ctrl !== q[0].ctrl || out_movop !== q[0].mov || out_dest !== q[0].dest) begin
                    n_fail++; $display("FAIL rand_head[%0d] got %h/%h/%h/%h exp %h/%h/%h/%h", i,
                                       out_result, out_ctrl, out_movop, out_dest, q[0].res, q[0].ctrl, q[0].mov, q[0].dest);
                end
            end else begin
                n_tests++; if (out_ctrl !== 4'h0) begin n_fail++; $display("FAIL rand_bubble_ctrl[%0d] got=%h exp=0", i, out_ctrl); end
            end
            n_tests++; if (fwd_valid !== model_fwd()) begin
                n_fail++; $display("FAIL rand_fwd[%0d] got=%b exp=%b", i, fwd_valid, model_fwd());
            end
        end
        flush = 1'b0;
        present(1'b0, rand_ent());
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_memwrite_flush();
        test_reset_mid();
        test_forward();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
